// File: rtl/can_sched_pkg.sv
// rtl/can_sched_pkg.sv - shared types and constants for the CAN TX scheduler
//
// Holds the scheduler state encoding, default CAN frame geometry and the
// ceiling-log2 helper used to size index and age fields.

package can_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUT  = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

    localparam int CAN_FRAME_W = 108;
    localparam int CAN_ID_LSB  = 76;
    localparam int CAN_ID_W    = 29;

    // Minimum result is 1 so a 1-bit index field is produced even for n <= 2.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/can_tx_sched_if.sv
// rtl/can_tx_sched_if.sv - requester and queue-put bundle of the CAN TX scheduler
//
// Signals:
//   req    per-requester frame-pending level, held until ack
//   din    flattened frames, requester k at [k*WIDTH +: WIDTH]
//   ack    one-cycle pulse, frame of that requester was written
//   q_full queue full flag
//   q_put  queue put strobe
//   q_din  frame presented to the queue
// Modports: master = scheduler side, slave = requesters/queue side.

interface can_tx_sched_if
    import can_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = CAN_FRAME_W
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] din;
    logic [NREQ-1:0]       ack;
    logic                  q_full;
    logic                  q_put;
    logic [WIDTH-1:0]      q_din;

    modport master (
        input  req, din, q_full,
        output ack, q_put, q_din
    );

    modport slave (
        output req, din, q_full,
        input  ack, q_put, q_din
    );
endinterface

// File: rtl/can_prio_sel.sv
// rtl/can_prio_sel.sv - combinational lowest-ID selector with aging override
//
// Ports:
//   req   in  NREQ       candidates
//   ids   in  NREQ*ID_W  flattened identifiers, candidate k at [k*ID_W +: ID_W]
//   aged  in  NREQ       candidate must win regardless of identifier
//   idx   out clog2(NREQ) winning index
//   valid out 1          at least one candidate present
// Ties on identifier resolve to the lowest index; among aged candidates the
// lowest index wins.

module can_prio_sel
    import can_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = CAN_ID_W,
    localparam int IDX_W = clog2(NREQ)
) (
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*ID_W-1:0] ids,
    input  logic [NREQ-1:0]      aged,
    output logic [IDX_W-1:0]     idx,
    output logic                 valid
);

    logic             found;
    logic [ID_W-1:0]  best_id;
    logic [IDX_W-1:0] best_idx;
    logic             aged_found;
    logic [IDX_W-1:0] aged_idx;

    always_comb begin
        found      = 1'b0;
        best_id    = '0;
        best_idx   = '0;
        aged_found = 1'b0;
        aged_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Strict less-than keeps the earlier (lower) index on an ID tie.
            if (req[k] && (!found || ids[k*ID_W +: ID_W] < best_id)) begin
                found    = 1'b1;
                best_id  = ids[k*ID_W +: ID_W];
                best_idx = IDX_W'(k);
            end
            if (req[k] && aged[k] && !aged_found) begin
                aged_found = 1'b1;
                aged_idx   = IDX_W'(k);
            end
        end
        valid = found;
        idx   = aged_found ? aged_idx : best_idx;
    end

endmodule

// File: rtl/can_tx_sched.sv
// rtl/can_tx_sched.sv - arbitrates requesters onto the shared CAN TX frame queue
//
// Ports:
//   GCLK      in  system clock
//   RES       in  asynchronous active-high reset
//   bus       if  requester/queue bundle (master modport)
//   grant_idx out index of the last or current grant
//   busy      out high while a put/gap sequence is in progress
// Each grant runs IDLE -> PUT -> GAP: q_put is high for exactly one cycle,
// ack pulses the following cycle, and the GAP cycle keeps put low long
// enough for the queue to release and for q_full to reflect the new entry.

module can_tx_sched
    import can_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = CAN_FRAME_W,
    parameter int ID_LSB  = CAN_ID_LSB,
    parameter int ID_W    = CAN_ID_W,
    parameter int AGE_MAX = 7,
    localparam int IDX_W  = clog2(NREQ)
) (
    input  logic                GCLK,
    input  logic                RES,
    can_tx_sched_if.master      bus,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                busy
);

    localparam int AGE_W = clog2(AGE_MAX + 1);

    sched_state_t         state;
    logic [AGE_W-1:0]     age [NREQ];
    logic [NREQ*ID_W-1:0] ids;
    logic [NREQ-1:0]      aged;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_valid;
    logic [WIDTH-1:0]     sel_frame;

    for (genvar g = 0; g < NREQ; g++) begin : g_req
        assign ids[g*ID_W +: ID_W] = bus.din[g*WIDTH + ID_LSB +: ID_W];
        assign aged[g]             = (age[g] == AGE_W'(AGE_MAX));
    end

    can_prio_sel #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_prio_sel (
        .req   (bus.req),
        .ids   (ids),
        .aged  (aged),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    always_comb begin
        sel_frame = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (IDX_W'(k) == sel_idx) begin
                sel_frame = bus.din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge GCLK or posedge RES) begin
        if (RES) begin
            state     <= ST_IDLE;
            bus.q_put <= 1'b0;
            bus.ack   <= '0;
            bus.q_din <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                age[k] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    // A full queue freezes both the grant and the aging state.
                    if (sel_valid && !bus.q_full) begin
                        bus.q_din <= sel_frame;
                        grant_idx <= sel_idx;
                        bus.q_put <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_PUT;
                        for (int k = 0; k < NREQ; k++) begin
                            if (IDX_W'(k) == sel_idx) begin
                                age[k] <= '0;
                            end else if (bus.req[k]) begin
                                if (age[k] != AGE_W'(AGE_MAX)) begin
                                    age[k] <= age[k] + 1'b1;
                                end
                            end else begin
                                age[k] <= '0;
                            end
                        end
                    end
                end
                ST_PUT: begin
                    bus.q_put <= 1'b0;
                    bus.ack   <= NREQ'(1) << grant_idx;
                    state     <= ST_GAP;
                end
                ST_GAP: begin
                    bus.ack <= '0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    bus.q_put <= 1'b0;
                    bus.ack   <= '0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_tx_sched.sv
// tb/tb_can_tx_sched.sv - directed scoreboard bench for can_tx_sched

module tb_can_tx_sched;
    import can_sched_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = CAN_FRAME_W;
    localparam int IDLSB = CAN_ID_LSB;
    localparam int IDW   = CAN_ID_W;
    localparam int QLEN  = 4;

    logic       GCLK = 1'b0;
    logic       RES;
    logic [1:0] grant_idx;
    logic       busy;

    can_tx_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    can_tx_sched #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .ID_LSB  (IDLSB),
        .ID_W    (IDW),
        .AGE_MAX (7)
    ) dut (
        .GCLK      (GCLK),
        .RES       (RES),
        .bus       (bus),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 GCLK = ~GCLK;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] frame;
    } exp_t;

    exp_t             sb[$];
    int               raise_q[$];
    logic [WIDTH-1:0] frames [NREQ];
    int               n_assert = 0;
    int               n_fail   = 0;
    int               cycle    = 0;
    int               last_ack = -1;
    int               pend_idx = 0;
    int               qcount   = 0;
    bit               spacing_en = 0;
    bit               prev_put   = 0;
    bit               pend_valid = 0;
    bit               use_q      = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_frame(input int k, input logic [IDW-1:0] id);
        logic [WIDTH-1:0] f;
        f[31:0]   = $urandom;
        f[63:32]  = $urandom;
        f[95:64]  = $urandom;
        f[107:96] = 12'($urandom);
        f[IDLSB +: IDW] = id;
        frames[k] = f;
        bus.din[k*WIDTH +: WIDTH] = f;
    endtask

    task automatic expect_grant(input int k);
        exp_t e;
        e.idx   = k;
        e.frame = frames[k];
        sb.push_back(e);
    endtask

    // One clock: sample at the falling edge, check ack/put against the
    // scoreboard, and play the requester/queue roles for the next edge.
    task automatic tick();
        exp_t            e;
        logic [NREQ-1:0] exp_ack;
        int              r;
        @(negedge GCLK);
        cycle++;
        exp_ack = '0;
        if (pend_valid) exp_ack[pend_idx] = 1'b1;
        chk("ack", bus.ack, exp_ack);
        if (pend_valid) begin
            if (spacing_en && last_ack >= 0) chk("ack_spacing", cycle - last_ack, 3);
            last_ack = cycle;
            bus.req[pend_idx] = 1'b0;
            if (use_q) begin
                qcount++;
                bus.q_full = (qcount >= QLEN);
            end
            if (raise_q.size() > 0) begin
                r = raise_q.pop_front();
                if (r >= 0) bus.req[r] = 1'b1;
            end
            pend_valid = 0;
        end
        if (prev_put) chk("put_gap", bus.q_put, 1'b0);
        if (bus.q_put === 1'b1) begin
            if (sb.size() == 0) begin
                chk("put_unexpected", bus.q_put, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("grant_idx", grant_idx, e.idx);
                chk("q_din", bus.q_din, e.frame);
                pend_valid = 1;
                pend_idx   = e.idx;
            end
        end
        prev_put = (bus.q_put === 1'b1);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while ((sb.size() > 0 || pend_valid || busy !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_pending"}, sb.size(), 0);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        RES        = 1'b1;
        bus.req    = '0;
        bus.din    = '0;
        bus.q_full = 1'b0;
        for (int i = 0; i < NREQ; i++) frames[i] = '0;
        repeat (2) tick();
        chk("rst_q_put", bus.q_put, 1'b0);
        chk("rst_ack", bus.ack, 4'b0000);
        chk("rst_q_din", bus.q_din, '0);
        chk("rst_grant_idx", grant_idx, 2'd0);
        chk("rst_busy", busy, 1'b0);
        RES = 1'b0;

        // Single request: put one cycle after sampling, ack the next.
        set_frame(0, 29'h100);
        expect_grant(0);
        bus.req = 4'b0001;
        tick();
        chk("single_put", bus.q_put, 1'b1);
        chk("single_busy_put", busy, 1'b1);
        tick();
        chk("single_ack", bus.ack, 4'b0001);
        chk("single_busy_gap", busy, 1'b1);
        tick();
        chk("single_busy_end", busy, 1'b0);
        chk("single_q_din_hold", bus.q_din, frames[0]);

        // Priority with an ID tie between requesters 1 and 2.
        set_frame(0, 29'h300);
        set_frame(1, 29'h050);
        set_frame(2, 29'h050);
        set_frame(3, 29'h7FF);
        expect_grant(1);
        expect_grant(2);
        expect_grant(0);
        expect_grant(3);
        spacing_en = 1;
        last_ack   = -1;
        bus.req    = 4'b1111;
        wait_done(40, "prio");
        spacing_en = 0;

        // Full stall: nothing granted while the queue is full.
        set_frame(1, 29'h0AB);
        bus.q_full = 1'b1;
        bus.req    = 4'b0010;
        repeat (10) begin
            tick();
            chk("stall_no_put", bus.q_put, 1'b0);
            chk("stall_not_busy", busy, 1'b0);
        end
        expect_grant(1);
        bus.q_full = 1'b0;
        tick();
        chk("stall_release_put", bus.q_put, 1'b1);
        wait_done(20, "stall");

        // Aging: requester 3 loses 7 times, wins the 8th, then re-requests
        // and loses again because its age restarted from zero.
        set_frame(0, 29'h001);
        set_frame(1, 29'h002);
        set_frame(2, 29'h003);
        set_frame(3, 29'h7FF);
        raise_q = '{1, 2, 0, 1, 2, 0, 1, 3};
        expect_grant(0); expect_grant(1); expect_grant(2);
        expect_grant(0); expect_grant(1); expect_grant(2);
        expect_grant(0); expect_grant(3); expect_grant(1);
        expect_grant(3);
        bus.req = 4'b1001;
        wait_done(80, "aging");

        // Reset during the put cycle: outputs drop at once, no ack follows.
        set_frame(2, 29'h123);
        expect_grant(2);
        bus.req = 4'b0100;
        tick();
        chk("rst_mid_put", bus.q_put, 1'b1);
        #2 RES = 1'b1;
        #1;
        chk("rst_mid_q_put", bus.q_put, 1'b0);
        chk("rst_mid_ack", bus.ack, 4'b0000);
        chk("rst_mid_busy", busy, 1'b0);
        pend_valid = 0;
        prev_put   = 0;
        repeat (2) tick();
        RES = 1'b0;
        expect_grant(2);
        wait_done(20, "rst_regrant");

        // Four-entry queue: four grants fill it, each drain admits one more.
        use_q      = 1;
        qcount     = 0;
        bus.q_full = 1'b0;
        set_frame(0, 29'h010);
        set_frame(1, 29'h020);
        set_frame(2, 29'h030);
        set_frame(3, 29'h040);
        raise_q = '{-1, -1, 0, 1};
        expect_grant(0);
        expect_grant(1);
        expect_grant(2);
        expect_grant(0);
        bus.req = 4'b1111;
        wait_done(40, "q_fill");
        chk("q_fill_count", qcount, QLEN);
        repeat (10) begin
            tick();
            chk("q_blocked_1", bus.q_put, 1'b0);
        end
        qcount--;
        bus.q_full = 1'b0;
        expect_grant(1);
        wait_done(20, "q_drain_1");
        repeat (10) begin
            tick();
            chk("q_blocked_2", bus.q_put, 1'b0);
        end
        qcount--;
        bus.q_full = 1'b0;
        expect_grant(3);
        wait_done(20, "q_drain_2");
        chk("q_final_count", qcount, QLEN);
        chk("q_final_req", bus.req, 4'b0000);
        use_q = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
